// File: rtl/reg_pipe.sv
// DEPTH-stage signed pipeline register chain with valid bits, stall, flush and occupancy.
// The capture edge is chosen at elaboration time. Reset is asynchronous and active-high.
module reg_pipe #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 2,
  parameter bit                    NEG_EDGE    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  localparam int                   OCC_W       = $clog2(DEPTH + 1)
) (
  input  logic                         PIPE_Clk,
  input  logic                         PIPE_Reset,
  input  logic                         PIPE_Set,
  input  logic                         PIPE_Flush,
  input  logic                         PIPE_Valid_In,
  input  logic signed [DATA_WIDTH-1:0] PIPE_Data_InBUS,
  output logic signed [DATA_WIDTH-1:0] PIPE_Data_OutBUS,
  output logic                         PIPE_Valid_Out,
  output logic [OCC_W-1:0]             PIPE_Occupancy
);

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("reg_pipe: DEPTH must be at least 1");
    end
  endgenerate

  logic signed [DATA_WIDTH-1:0] data_q [DEPTH];
  logic signed [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]             vld_q;
  logic [DEPTH-1:0]             vld_d;

  // Flush beats set. A stalled chain keeps every stage exactly as it is.
  always_comb begin
    // NOTE: every stage is given its held value first, so no path through the block can infer a latch.
    data_d = data_q;
    vld_d  = vld_q;
    if (PIPE_Flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = RESET_VALUE;
      end
      vld_d = '0;
    end else if (PIPE_Set) begin
      data_d[0] = PIPE_Data_InBUS;
      vld_d[0]  = PIPE_Valid_In;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
    end
  end

  // Only the selected edge is wired to the state register. The other edge cannot touch state.
  generate
    if (NEG_EDGE) begin : g_neg
      always_ff @(negedge PIPE_Clk or posedge PIPE_Reset) begin
        // NOTE: the data stages are reset as well as the valid bits, because RESET_VALUE must be visible at the output.
        if (PIPE_Reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= RESET_VALUE;
          end
          vld_q <= '0;
        end else begin
          // NOTE: non-blocking assignments let every stage sample its neighbour's old value.
          data_q <= data_d;
          vld_q  <= vld_d;
        end
      end
    end else begin : g_pos
      always_ff @(posedge PIPE_Clk or posedge PIPE_Reset) begin
        if (PIPE_Reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= RESET_VALUE;
          end
          vld_q <= '0;
        end else begin
          data_q <= data_d;
          vld_q  <= vld_d;
        end
      end
    end
  endgenerate

  always_comb begin
    PIPE_Occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      PIPE_Occupancy = PIPE_Occupancy + OCC_W'(vld_q[i]);
    end
  end

  assign PIPE_Data_OutBUS = data_q[DEPTH-1];
  assign PIPE_Valid_Out   = vld_q[DEPTH-1];

endmodule

// File: tb/tb_reg_pipe.sv
// Directed bench for reg_pipe. It uses a 3-deep falling-edge chain and a 1-deep rising-edge register.
// The expected values in the vector table are worked out by hand from the reset state.
module tb_reg_pipe;

  logic clk;
  logic rst;

  logic               a_set, a_flush, a_vin;
  logic signed [31:0] a_din, a_dout;
  logic               a_vout;
  logic [1:0]         a_occ;

  logic               b_set, b_flush, b_vin;
  logic signed [31:0] b_din, b_dout;
  logic               b_vout;
  logic [0:0]         b_occ;

  int checks = 0;
  int errors = 0;

  reg_pipe #(.DATA_WIDTH(32), .DEPTH(3), .NEG_EDGE(1'b1), .RESET_VALUE(32'hDEAD_BEEF)) dut_a (
    .PIPE_Clk(clk), .PIPE_Reset(rst), .PIPE_Set(a_set), .PIPE_Flush(a_flush),
    .PIPE_Valid_In(a_vin), .PIPE_Data_InBUS(a_din), .PIPE_Data_OutBUS(a_dout),
    .PIPE_Valid_Out(a_vout), .PIPE_Occupancy(a_occ)
  );

  reg_pipe #(.DATA_WIDTH(32), .DEPTH(1), .NEG_EDGE(1'b0), .RESET_VALUE(32'h0)) dut_b (
    .PIPE_Clk(clk), .PIPE_Reset(rst), .PIPE_Set(b_set), .PIPE_Flush(b_flush),
    .PIPE_Valid_In(b_vin), .PIPE_Data_InBUS(b_din), .PIPE_Data_OutBUS(b_dout),
    .PIPE_Valid_Out(b_vout), .PIPE_Occupancy(b_occ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_a(input string name, input logic [31:0] d, input logic v, input int occ);
    check({name, " data"}, a_dout, d);
    check({name, " valid"}, {31'b0, a_vout}, {31'b0, v});
    check({name, " occ"}, {30'b0, a_occ}, occ);
  endtask

  typedef struct {
    logic        set;
    logic        flush;
    logic        vin;
    logic [31:0] din;
    logic [31:0] exp_out;
    logic        exp_vout;
    int          exp_occ;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  initial begin
    // Fill, advance, stall, bubbles, flush with set, refill, then a plain flush.
    vecs[0]  = '{1, 0, 1, 32'd1,    32'hDEAD_BEEF, 0, 1};
    vecs[1]  = '{1, 0, 1, 32'd2,    32'hDEAD_BEEF, 0, 2};
    vecs[2]  = '{1, 0, 1, 32'd3,    32'd1,         1, 3};
    vecs[3]  = '{1, 0, 1, 32'd4,    32'd2,         1, 3};
    vecs[4]  = '{1, 0, 1, 32'd5,    32'd3,         1, 3};
    vecs[5]  = '{1, 0, 1, 32'd6,    32'd4,         1, 3};
    vecs[6]  = '{1, 0, 1, 32'd7,    32'd5,         1, 3};
    vecs[7]  = '{0, 0, 1, 32'd11,   32'd5,         1, 3};
    vecs[8]  = '{0, 0, 0, 32'd12,   32'd5,         1, 3};
    vecs[9]  = '{0, 0, 1, 32'd13,   32'd5,         1, 3};
    vecs[10] = '{0, 0, 0, 32'd14,   32'd5,         1, 3};
    vecs[11] = '{1, 0, 1, 32'd8,    32'd6,         1, 3};
    vecs[12] = '{1, 0, 1, 32'hA,    32'd7,         1, 3};
    vecs[13] = '{1, 0, 0, 32'hB,    32'd8,         1, 2};
    vecs[14] = '{1, 0, 1, 32'hC,    32'hA,         1, 2};
    vecs[15] = '{1, 0, 1, 32'h31,   32'hB,         0, 2};
    vecs[16] = '{1, 0, 1, 32'h32,   32'hC,         1, 3};
    vecs[17] = '{1, 1, 1, 32'd9,    32'hDEAD_BEEF, 0, 0};
    vecs[18] = '{1, 0, 1, 32'h20,   32'hDEAD_BEEF, 0, 1};
    vecs[19] = '{1, 0, 1, 32'h21,   32'hDEAD_BEEF, 0, 2};
    vecs[20] = '{1, 0, 1, 32'h22,   32'h20,        1, 3};
    vecs[21] = '{0, 1, 0, 32'h23,   32'hDEAD_BEEF, 0, 0};

    rst = 1'b1;
    a_set = 0; a_flush = 0; a_vin = 0; a_din = '0;
    b_set = 0; b_flush = 0; b_vin = 0; b_din = '0;
    #1;
    check_a("reset_a", 32'hDEAD_BEEF, 1'b0, 0);
    check("reset_b data", b_dout, 32'h0);

    @(posedge clk); #1;
    rst = 1'b0;

    // Inputs change just after a rising edge. Outputs are sampled after the falling edge,
    // and again after the next rising edge to show that nothing moves on that edge.
    for (int i = 0; i < NV; i++) begin
      a_set = vecs[i].set; a_flush = vecs[i].flush; a_vin = vecs[i].vin; a_din = vecs[i].din;
      @(negedge clk); #1;
      check_a($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_vout, vecs[i].exp_occ);
      @(posedge clk); #1;
      check($sformatf("vec%0d rise data", i), a_dout, vecs[i].exp_out);
      check($sformatf("vec%0d rise occ", i), {30'b0, a_occ}, vecs[i].exp_occ);
    end

    // Load two words, then assert reset between edges. The chain must clear with no clock edge.
    a_set = 1; a_flush = 0; a_vin = 1; a_din = 32'h41;
    @(negedge clk); #1;
    a_din = 32'h42;
    @(negedge clk); #1;
    check("preload occ", {30'b0, a_occ}, 32'd2);
    rst = 1'b1;
    #1;
    check_a("async_reset", 32'hDEAD_BEEF, 1'b0, 0);
    a_din = 32'h55;
    @(negedge clk); #1;
    check_a("reset_hold", 32'hDEAD_BEEF, 1'b0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    a_set = 0;

    // DEPTH=1 on the rising edge. The negative value must pass through bit-exact.
    @(negedge clk); #1;
    b_set = 1; b_vin = 1; b_din = 32'sh8000_0000;
    #1;
    check("b before rise", b_dout, 32'h0);
    @(posedge clk); #1;
    check("b rise data", b_dout, 32'h8000_0000);
    check("b rise valid", {31'b0, b_vout}, 32'd1);
    check("b rise occ", {31'b0, b_occ}, 32'd1);
    check("b signed", {31'b0, (b_dout < 0)}, 32'd1);
    b_din = 32'sd1;
    @(negedge clk); #1;
    check("b fall hold", b_dout, 32'h8000_0000);
    b_set = 0;
    @(posedge clk); #1;
    check("b stall", b_dout, 32'h8000_0000);
    b_flush = 1;
    @(posedge clk); #1;
    check("b flush data", b_dout, 32'h0);
    check("b flush occ", {31'b0, b_occ}, 32'd0);
    b_flush = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
